// File: rtl/vga_timing_gen_if.sv
// Raster timing bus shared by every draw stage: position, sync, blanking and
// the line/frame strobes used by the game logic.
interface vga_timing_gen_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic        frame_tick;
  logic        line_tick;

  modport master (
    output hcount, vcount, hsync, vsync, hblnk, vblnk, frame_tick, line_tick
  );

  modport slave (
    input hcount, vcount, hsync, vsync, hblnk, vblnk, frame_tick, line_tick
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator (default 1024x768@60 on 65 MHz). All outputs are
// flops decoded from the next counter values, so they align with hcount/vcount.
module vga_timing_gen #(
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 160,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 29
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  vga_timing_gen_if.master         vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 2047 || V_TOTAL > 2047) begin : g_size_check
    $error("vga_timing_gen: H_TOTAL/V_TOTAL must fit in 11 bits");
  end

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT      = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT      = 11'(V_ACTIVE);
  localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic        started_q;
  logic [10:0] h_q, v_q;
  logic [10:0] h_next, v_next;
  logic        hsync_q, vsync_q, hblnk_q, vblnk_q;
  logic        frame_tick_q, line_tick_q;

  // The first enabled edge after reset presents (0,0) rather than advancing.
  always_comb begin
    h_next = h_q;
    v_next = v_q;
    if (!started_q) begin
      h_next = 11'd0;
      v_next = 11'd0;
    end else if (h_q == H_LAST) begin
      h_next = 11'd0;
      v_next = (v_q == V_LAST) ? 11'd0 : v_q + 11'd1;
    end else begin
      h_next = h_q + 11'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started_q    <= 1'b0;
      h_q          <= 11'd0;
      v_q          <= 11'd0;
      hsync_q      <= 1'b0;
      vsync_q      <= 1'b0;
      hblnk_q      <= 1'b0;
      vblnk_q      <= 1'b0;
      frame_tick_q <= 1'b0;
      line_tick_q  <= 1'b0;
    end else if (en) begin
      started_q    <= 1'b1;
      h_q          <= h_next;
      v_q          <= v_next;
      hsync_q      <= (h_next >= HS_START) && (h_next < HS_END);
      vsync_q      <= (v_next >= VS_START) && (v_next < VS_END);
      hblnk_q      <= (h_next >= H_ACT);
      vblnk_q      <= (v_next >= V_ACT);
      line_tick_q  <= (h_next == 11'd0);
      frame_tick_q <= (h_next == 11'd0) && (v_next == 11'd0);
    end else begin
      // Stalled: position and decodes hold, strobes must not repeat.
      line_tick_q  <= 1'b0;
      frame_tick_q <= 1'b0;
    end
  end

  assign vga.hcount     = h_q;
  assign vga.vcount     = v_q;
  assign vga.hsync      = hsync_q;
  assign vga.vsync      = vsync_q;
  assign vga.hblnk      = hblnk_q;
  assign vga.vblnk      = vblnk_q;
  assign vga.frame_tick = frame_tick_q;
  assign vga.line_tick  = line_tick_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: default-mode line timing and async reset, plus a small
// mode (14x7 raster) for table-driven vectors and whole-frame timing.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n_big = 1'b0, en_big = 1'b0;
  logic rst_n_small = 1'b0, en_small = 1'b0;

  vga_timing_gen_if bus_big ();
  vga_timing_gen_if bus_small ();

  vga_timing_gen dut_big (
    .clk   (clk),
    .rst_n (rst_n_big),
    .en    (en_big),
    .vga   (bus_big)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) dut_small (
    .clk   (clk),
    .rst_n (rst_n_small),
    .en    (en_small),
    .vga   (bus_small)
  );

  int checks = 0;
  int errors = 0;

  // flags packing: {hsync, vsync, hblnk, vblnk, frame_tick, line_tick}
  typedef struct {
    logic rst_n;
    logic en;
    int   n;
    int   h;
    int   v;
    int   flags;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic e, input int n,
                              input int h, input int v, input int f);
    vec_t t;
    t.rst_n = r; t.en = e; t.n = n; t.h = h; t.v = v; t.flags = f;
    return t;
  endfunction

  function automatic int smallFlags();
    return int'({bus_small.hsync, bus_small.vsync, bus_small.hblnk,
                 bus_small.vblnk, bus_small.frame_tick, bus_small.line_tick});
  endfunction

  function automatic int bigFlags();
    return int'({bus_big.hsync, bus_big.vsync, bus_big.hblnk,
                 bus_big.vblnk, bus_big.frame_tick, bus_big.line_tick});
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: actual %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t t);
    rst_n_small = t.rst_n;
    en_small    = t.en;
    repeat (t.n) @(posedge clk);
    #1;
  endtask

  task automatic stepSmall(input logic e);
    en_small = e;
    @(posedge clk);
    #1;
  endtask

  task automatic stepBig();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int bad, first_hb, first_hs, last_hs, hs_cnt, tick_bad;
    int cnt, vs_cnt, vb_cnt, imp_bad, found;
    logic e;

    // ---------------- default mode: reset and one line ----------------
    en_big = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("big_reset_hcount", int'(bus_big.hcount), 0);
    checkOutput("big_reset_vcount", int'(bus_big.vcount), 0);
    checkOutput("big_reset_flags", bigFlags(), 0);

    rst_n_big = 1'b1;
    stepBig();
    checkOutput("big_start_hcount", int'(bus_big.hcount), 0);
    checkOutput("big_start_vcount", int'(bus_big.vcount), 0);
    checkOutput("big_start_flags", bigFlags(), 6'b000011);

    bad = 0; first_hb = -1; first_hs = -1; last_hs = -1; hs_cnt = 0; tick_bad = 0;
    for (int k = 1; k < 1344; k++) begin
      stepBig();
      if (int'(bus_big.hcount) != k || bus_big.vcount != 11'd0) bad++;
      if (bus_big.hblnk != (k >= 1024)) bad++;
      if (bus_big.vblnk || bus_big.vsync) bad++;
      if (bus_big.line_tick || bus_big.frame_tick) tick_bad++;
      if (bus_big.hblnk && first_hb < 0) first_hb = int'(bus_big.hcount);
      if (bus_big.hsync) begin
        hs_cnt++;
        if (first_hs < 0) first_hs = int'(bus_big.hcount);
        last_hs = int'(bus_big.hcount);
      end
    end
    checkOutput("big_line_sequence_errors", bad, 0);
    checkOutput("big_hblnk_rise", first_hb, 1024);
    checkOutput("big_hsync_width", hs_cnt, 136);
    checkOutput("big_hsync_first", first_hs, 1048);
    checkOutput("big_hsync_last", last_hs, 1183);
    checkOutput("big_line_ticks_midline", tick_bad, 0);

    stepBig();
    checkOutput("big_wrap_hcount", int'(bus_big.hcount), 0);
    checkOutput("big_wrap_vcount", int'(bus_big.vcount), 1);
    checkOutput("big_wrap_flags", bigFlags(), 6'b000001);

    // ---------------- default mode: async reset mid-line ----------------
    repeat (500) stepBig();
    checkOutput("big_pre_reset_hcount", int'(bus_big.hcount), 500);
    checkOutput("big_pre_reset_vcount", int'(bus_big.vcount), 1);
    #2 rst_n_big = 1'b0;
    #1;
    checkOutput("big_async_reset_pos", int'({bus_big.hcount, bus_big.vcount}), 0);
    checkOutput("big_async_reset_flags", bigFlags(), 0);
    repeat (2) @(posedge clk);
    #1 rst_n_big = 1'b1;
    stepBig();
    checkOutput("big_restart_hcount", int'(bus_big.hcount), 0);
    checkOutput("big_restart_vcount", int'(bus_big.vcount), 0);
    checkOutput("big_restart_flags", bigFlags(), 6'b000011);

    // ---------------- small mode: table-driven vectors ----------------
    vecs.push_back(mk(1'b0, 1'b1,  3,  0, 0, 6'b000000));
    vecs.push_back(mk(1'b1, 1'b1,  1,  0, 0, 6'b000011));
    vecs.push_back(mk(1'b1, 1'b1,  1,  1, 0, 6'b000000));
    vecs.push_back(mk(1'b1, 1'b0,  2,  1, 0, 6'b000000));
    vecs.push_back(mk(1'b1, 1'b1,  6,  7, 0, 6'b000000));
    vecs.push_back(mk(1'b1, 1'b1,  1,  8, 0, 6'b001000));
    vecs.push_back(mk(1'b1, 1'b1,  2, 10, 0, 6'b101000));
    vecs.push_back(mk(1'b1, 1'b0,  3, 10, 0, 6'b101000));
    vecs.push_back(mk(1'b1, 1'b1,  1, 11, 0, 6'b101000));
    vecs.push_back(mk(1'b1, 1'b1,  1, 12, 0, 6'b001000));
    vecs.push_back(mk(1'b1, 1'b1,  1, 13, 0, 6'b001000));
    vecs.push_back(mk(1'b1, 1'b1,  1,  0, 1, 6'b000001));
    vecs.push_back(mk(1'b1, 1'b1, 42,  0, 4, 6'b000101));
    vecs.push_back(mk(1'b1, 1'b1, 14,  0, 5, 6'b010101));
    vecs.push_back(mk(1'b1, 1'b1, 13, 13, 5, 6'b011100));
    vecs.push_back(mk(1'b1, 1'b1,  1,  0, 6, 6'b000101));
    vecs.push_back(mk(1'b1, 1'b1, 13, 13, 6, 6'b001100));
    vecs.push_back(mk(1'b1, 1'b1,  1,  0, 0, 6'b000011));
    vecs.push_back(mk(1'b1, 1'b0,  1,  0, 0, 6'b000000));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d_hcount", i), int'(bus_small.hcount), vecs[i].h);
      checkOutput($sformatf("vec%0d_vcount", i), int'(bus_small.vcount), vecs[i].v);
      checkOutput($sformatf("vec%0d_flags", i), smallFlags(), vecs[i].flags);
    end

    // ---------------- small mode: full-frame period ----------------
    found = 0;
    for (int i = 0; i < 400 && found == 0; i++) begin
      stepSmall(1'b1);
      if (bus_small.frame_tick) found = 1;
    end
    checkOutput("small_frame_tick_seen", found, 1);

    found = 0; cnt = 0; vs_cnt = 0; vb_cnt = 0; imp_bad = 0;
    for (int i = 0; i < 400 && found == 0; i++) begin
      stepSmall(1'b1);
      cnt++;
      if (bus_small.vsync) vs_cnt++;
      if (bus_small.vblnk) vb_cnt++;
      if (bus_small.frame_tick && !bus_small.line_tick) imp_bad++;
      if (bus_small.frame_tick) found = 1;
    end
    checkOutput("small_frame_period_found", found, 1);
    checkOutput("small_frame_period", cnt, 98);
    checkOutput("small_vsync_cycles", vs_cnt, 14);
    checkOutput("small_vblnk_cycles", vb_cnt, 42);
    checkOutput("small_frame_implies_line", imp_bad, 0);

    // ---------------- small mode: 1-of-2 enable gating ----------------
    e = 1'b0; found = 0;
    for (int i = 0; i < 800 && found == 0; i++) begin
      e = ~e;
      stepSmall(e);
      if (bus_small.frame_tick) found = 1;
    end
    checkOutput("gated_frame_tick_seen", found, 1);

    found = 0; cnt = 0; tick_bad = 0;
    for (int i = 0; i < 800 && found == 0; i++) begin
      e = ~e;
      stepSmall(e);
      cnt++;
      if (!e && (bus_small.frame_tick || bus_small.line_tick)) tick_bad++;
      if (bus_small.frame_tick) found = 1;
    end
    checkOutput("gated_frame_period_found", found, 1);
    checkOutput("gated_frame_period", cnt, 196);
    checkOutput("gated_ticks_while_disabled", tick_bad, 0);

    // ---------------- small mode: async reset mid-frame ----------------
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      stepSmall(1'b1);
      if (bus_small.hcount == 11'd5 && bus_small.vcount == 11'd3) found = 1;
    end
    checkOutput("small_reach_5_3", found, 1);
    #2 rst_n_small = 1'b0;
    #1;
    checkOutput("small_async_reset_pos", int'({bus_small.hcount, bus_small.vcount}), 0);
    checkOutput("small_async_reset_flags", smallFlags(), 0);
    repeat (3) stepSmall(1'b1);
    checkOutput("small_held_reset_flags", smallFlags(), 0);
    rst_n_small = 1'b1;
    stepSmall(1'b1);
    checkOutput("small_restart_pos", int'({bus_small.hcount, bus_small.vcount}), 0);
    checkOutput("small_restart_flags", smallFlags(), 6'b000011);
    stepSmall(1'b1);
    checkOutput("small_after_restart_hcount", int'(bus_small.hcount), 1);
    checkOutput("small_after_restart_flags", smallFlags(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
